// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (port 1 wins), busy scoreboard.
// Writes land at the edge, reads are combinational with optional bypass; no backpressure, ready gates use after the reset sweep.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr0,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata0,
    input  logic [XLEN-1:0]       wdata1,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    input  logic                  busy_set,
    input  logic [AW-1:0]         busy_addr,
    output logic [NREGS-1:0]      busy,
    output logic                  wcollide
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW:0] IDX_LAST = (AW+1)'(NREGS - 1);

    state_t            state;
    logic [AW:0]       idx;
    logic [XLEN-1:0]   mem [NREGS];
    logic              wr0, wr1, collide, set_ok;
    logic [NREGS-1:0]  busy_nxt;

    // Writes to a hardwired x0 vanish entirely, so they can never collide.
    assign wr0     = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1     = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign collide = wr0 && wr1 && (waddr0 == waddr1);
    assign set_ok  = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            idx      <= '0;
            ready    <= 1'b0;
            busy     <= '0;
            wcollide <= 1'b0;
        end else if (state == INIT) begin
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            busy     <= busy_nxt;
            wcollide <= collide;
        end
    end

    // Array kept free of reset so it maps onto distributed RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[idx[AW-1:0]] <= '0;
            end else begin
                if (wr0) mem[waddr0] <= wdata0;
                if (wr1) mem[waddr1] <= wdata1;
            end
        end
    end

    // Set beats clear: a newer producer is already in flight for that register.
    always_comb begin
        busy_nxt = busy;
        if (wr0)    busy_nxt[waddr0]    = 1'b0;
        if (wr1)    busy_nxt[waddr1]    = 1'b0;
        if (set_ok) busy_nxt[busy_addr] = 1'b1;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (state == RUN) begin
                rdata[i*XLEN +: XLEN] = mem[raddr[i*AW +: AW]];
                if ((BYPASS != 0) && we0 && (waddr0 == raddr[i*AW +: AW]))
                    rdata[i*XLEN +: XLEN] = wdata0;
                if ((BYPASS != 0) && we1 && (waddr1 == raddr[i*AW +: AW]))
                    rdata[i*XLEN +: XLEN] = wdata1;
                if ((ZERO_REG != 0) && (raddr[i*AW +: AW] == '0))
                    rdata[i*XLEN +: XLEN] = '0;
            end
        end
    end

endmodule
